// File: rtl/trig_gen_pkg.sv
// Shared encodings for the multi-channel trigger generator: operating modes,
// trigger source codes, controller states and a popcount helper.
package trig_gen_pkg;

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,   // any masked channel rising
        MODE_MAJ = 2'b01,   // masked channel count crosses majority_n
        MODE_EXT = 2'b10,   // external trigger only
        MODE_CYC = 2'b11    // cyclic timer only
    } mode_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_EXT  = 2'b01,
        SRC_SELF = 2'b10,
        SRC_CYC  = 2'b11
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    // Number of set bits in a channel vector padded to 16 bits.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/trig_gen_nch_cyc_timer.sv
// Free-running cyclic trigger timer: counts 0..cyc_period-1 and emits a
// one-cycle pulse on the wrap. Disabled or zero period parks the count at 0.
module cyc_timer #(
    parameter int CYC_W = 24
) (
    input  logic             init_clk,
    input  logic             reset_i,
    input  logic             cyc_en,
    input  logic [CYC_W-1:0] cyc_period,
    output logic             cyctrig_pls
);

    localparam logic [CYC_W-1:0] ONE = CYC_W'(1);

    logic [CYC_W-1:0] count;

    // Period counter with registered wrap pulse.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            count       <= '0;
            cyctrig_pls <= 1'b0;
        end else if (!cyc_en || (cyc_period == '0)) begin
            count       <= '0;
            cyctrig_pls <= 1'b0;
        end else if (count >= (cyc_period - ONE)) begin
            count       <= '0;
            cyctrig_pls <= 1'b1;
        end else begin
            count       <= count + ONE;
            cyctrig_pls <= 1'b0;
        end
    end

endmodule

// File: rtl/trig_gen_nch.sv
// N-channel trigger generator: edge-detects channel/external levels, merges
// self, external and cyclic requests by mode, and issues a fixed-width
// trig_out pulse followed by an optional hold-off window.
module trig_gen_nch
    import trig_gen_pkg::*;
#(
    parameter  int N_CH   = 3,
    parameter  int CYC_W  = 24,
    parameter  int HOLD_W = 8,
    parameter  int PW     = 4,
    localparam int MAJ_W  = $clog2(N_CH + 1)
) (
    input  logic              init_clk,
    input  logic              reset_i,
    input  logic              trigger_stun,
    input  logic [1:0]        mode,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [MAJ_W-1:0]  majority_n,
    input  logic [N_CH-1:0]   overth,
    input  logic              trig_in,
    input  logic              cyc_en,
    input  logic [CYC_W-1:0]  cyc_period,
    input  logic [HOLD_W-1:0] holdoff,
    output logic              trig_out,
    output logic              cyctrig_pls,
    output logic [1:0]        trig_src,
    output logic              busy,
    output logic [31:0]       trig_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int PW_W = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [PW_W-1:0]   PW_LAST  = PW_W'(PW - 1);
    localparam logic [PW_W-1:0]   PW_ONE   = PW_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    // Two-stage sampling of levels (S1 = newest, S2 = previous S1)
    logic [N_CH-1:0] s1_ov, s2_ov;
    logic            s1_trig, s2_trig;
    logic            s1_cyc;

    // Mode-filtered requests, registered one cycle before acceptance
    logic self_req, ext_req, cyc_req;
    logic req_self_q, req_ext_q, req_cyc_q;

    logic [4:0] pc1, pc2, maj_thr;
    mode_t      mode_e;

    state_t            state;
    src_t              trig_src_q;
    logic [PW_W-1:0]   pw_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic any_req, accept, rejected;

    cyc_timer #(.CYC_W(CYC_W)) u_cyc_timer (
        .init_clk    (init_clk),
        .reset_i     (reset_i),
        .cyc_en      (cyc_en),
        .cyc_period  (cyc_period),
        .cyctrig_pls (cyctrig_pls)
    );

    assign mode_e  = mode_t'(mode);
    assign pc1     = popcount16(16'(s1_ov & ch_mask));
    assign pc2     = popcount16(16'(s2_ov & ch_mask));
    assign maj_thr = 5'(majority_n);

    // Input sampling stages and request register.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            s1_ov      <= '0;
            s2_ov      <= '0;
            s1_trig    <= 1'b0;
            s2_trig    <= 1'b0;
            s1_cyc     <= 1'b0;
            req_self_q <= 1'b0;
            req_ext_q  <= 1'b0;
            req_cyc_q  <= 1'b0;
        end else begin
            s1_ov      <= overth;
            s2_ov      <= s1_ov;
            s1_trig    <= trig_in;
            s2_trig    <= s1_trig;
            s1_cyc     <= cyctrig_pls;
            req_self_q <= self_req;
            req_ext_q  <= ext_req;
            req_cyc_q  <= cyc_req;
        end
    end

    // Request formation from the S1/S2 pair under the current mode and mask.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and gives every output a
        // default first, so no path leaves a value held (no latch inferred).
        self_req = 1'b0;
        ext_req  = 1'b0;
        cyc_req  = 1'b0;
        case (mode_e)
            MODE_OR:  self_req = |(s1_ov & ~s2_ov & ch_mask);
            MODE_MAJ: self_req = (majority_n != '0) && (pc1 >= maj_thr) && (pc2 < maj_thr);
            default:  self_req = 1'b0;
        endcase
        ext_req = s1_trig & ~s2_trig & (mode_e != MODE_CYC);
        cyc_req = s1_cyc & (mode_e != MODE_EXT);
    end

    assign any_req  = req_self_q | req_ext_q | req_cyc_q;
    assign accept   = any_req && (state == ST_IDLE) && !trigger_stun;
    assign rejected = any_req && !accept;
    assign trig_src = trig_src_q;

    // Trigger controller: IDLE -> PULSE (PW cycles) -> optional HOLD -> IDLE.
    always_ff @(posedge init_clk) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            trig_out   <= 1'b0;
            busy       <= 1'b0;
            trig_src_q <= SRC_NONE;
            trig_cnt   <= '0;
            drop_cnt   <= '0;
            pw_cnt     <= '0;
            hold_cnt   <= '0;
        end else begin
            if (rejected && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_PULSE;
                        trig_out <= 1'b1;
                        busy     <= 1'b1;
                        pw_cnt   <= PW_LAST;
                        trig_cnt <= trig_cnt + 32'd1;
                        if (req_ext_q)       trig_src_q <= SRC_EXT;
                        else if (req_self_q) trig_src_q <= SRC_SELF;
                        else                 trig_src_q <= SRC_CYC;
                    end
                end
                ST_PULSE: begin
                    if (pw_cnt == '0) begin
                        trig_out <= 1'b0;
                        if (holdoff != '0) begin
                            state    <= ST_HOLD;
                            hold_cnt <= holdoff - HOLD_ONE;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        pw_cnt <= pw_cnt - PW_ONE;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    trig_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_gen_nch.sv
// Directed bench for trig_gen_nch: reset, self-OR, majority, cyclic,
// simultaneous sources with hold-off, stun, reset mid-pulse, back-to-back.
module tb_trig_gen_nch;

    localparam int N_CH   = 3;
    localparam int CYC_W  = 24;
    localparam int HOLD_W = 8;
    localparam int PW     = 4;

    logic              init_clk;
    logic              reset_i;
    logic              trigger_stun;
    logic [1:0]        mode;
    logic [N_CH-1:0]   ch_mask;
    logic [1:0]        majority_n;
    logic [N_CH-1:0]   overth;
    logic              trig_in;
    logic              cyc_en;
    logic [CYC_W-1:0]  cyc_period;
    logic [HOLD_W-1:0] holdoff;
    logic              trig_out;
    logic              cyctrig_pls;
    logic [1:0]        trig_src;
    logic              busy;
    logic [31:0]       trig_cnt;
    logic [15:0]       drop_cnt;

    int checks   = 0;
    int failures = 0;

    trig_gen_nch #(.N_CH(N_CH), .CYC_W(CYC_W), .HOLD_W(HOLD_W), .PW(PW)) dut (
        .init_clk     (init_clk),
        .reset_i      (reset_i),
        .trigger_stun (trigger_stun),
        .mode         (mode),
        .ch_mask      (ch_mask),
        .majority_n   (majority_n),
        .overth       (overth),
        .trig_in      (trig_in),
        .cyc_en       (cyc_en),
        .cyc_period   (cyc_period),
        .holdoff      (holdoff),
        .trig_out     (trig_out),
        .cyctrig_pls  (cyctrig_pls),
        .trig_src     (trig_src),
        .busy         (busy),
        .trig_cnt     (trig_cnt),
        .drop_cnt     (drop_cnt)
    );

    initial begin
        init_clk = 1'b0;
        forever #5 init_clk = ~init_clk;
    end

    // Advance n rising edges, then settle 1 ns so outputs are sampled away from the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge init_clk);
            #1;
        end
    endtask

    // Two reset edges; reset_i drops right after the last one.
    task automatic apply_reset;
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
    endtask

    task automatic test_reset;
        trigger_stun = 1'b0; mode = 2'b00; ch_mask = 3'b111; majority_n = 2'd0;
        overth = '0; trig_in = 1'b0; cyc_en = 1'b0; cyc_period = '0; holdoff = '0;
        reset_i = 1'b1;
        tick(2);
        checks++;
        if ({trig_out, cyctrig_pls, busy, trig_src} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {trig_out, cyctrig_pls, busy, trig_src});
        end
        checks++;
        if (trig_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_counts got trig_cnt=%0d drop_cnt=%0d exp 0 0", trig_cnt, drop_cnt);
        end
        reset_i = 1'b0;
        tick(2);
    endtask

    task automatic test_self_or;
        int hi_bad;
        mode = 2'b00; ch_mask = 3'b111; holdoff = '0; overth = 3'b000;
        tick(2);
        overth = 3'b010;   // first sampled at next edge (E0)
        tick(2);           // E0+1
        checks++;
        if (trig_out !== 1'b0) begin
            failures++;
            $display("FAIL self_or_early got=%b exp=0", trig_out);
        end
        hi_bad = 0;
        for (int i = 0; i < PW; i++) begin   // E0+2 .. E0+5
            tick(1);
            if ({trig_out, busy} !== 2'b11) hi_bad++;
        end
        checks++;
        if (hi_bad != 0) begin
            failures++;
            $display("FAIL self_or_pulse got=%0d bad cycles exp=0", hi_bad);
        end
        tick(1);           // E0+6
        checks++;
        if ({trig_out, busy} !== 2'b00) begin
            failures++;
            $display("FAIL self_or_end got=%b exp=00", {trig_out, busy});
        end
        checks++;
        if (trig_src !== 2'b10 || trig_cnt !== 32'd1) begin
            failures++;
            $display("FAIL self_or_src got src=%b cnt=%0d exp src=10 cnt=1", trig_src, trig_cnt);
        end
        overth = 3'b000;
        tick(3);
    endtask

    task automatic test_majority;
        apply_reset();
        mode = 2'b01; majority_n = 2'd2; ch_mask = 3'b111;
        overth = 3'b001;
        tick(6);
        checks++;
        if (trig_cnt !== 32'd0) begin
            failures++;
            $display("FAIL maj_below got=%0d exp=0", trig_cnt);
        end
        overth = 3'b011;
        tick(2);
        checks++;
        if (trig_out !== 1'b0) begin
            failures++;
            $display("FAIL maj_early got=%b exp=0", trig_out);
        end
        tick(1);
        checks++;
        if (trig_out !== 1'b1 || trig_src !== 2'b10) begin
            failures++;
            $display("FAIL maj_fire got out=%b src=%b exp out=1 src=10", trig_out, trig_src);
        end
        tick(4);
        overth = 3'b111;
        tick(8);
        checks++;
        if (trig_cnt !== 32'd1) begin
            failures++;
            $display("FAIL maj_stay_high got=%0d exp=1", trig_cnt);
        end
        majority_n = 2'd0;
        overth = 3'b000;
        tick(3);
        overth = 3'b111;
        tick(6);
        checks++;
        if (trig_cnt !== 32'd1 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL maj_zero got cnt=%0d drop=%0d exp cnt=1 drop=0", trig_cnt, drop_cnt);
        end
        overth = 3'b000;
        majority_n = 2'd2;
        tick(3);
    endtask

    task automatic test_cyclic;
        int pls_bad, pls_cnt, edge_bad;
        apply_reset();
        mode = 2'b11; holdoff = '0; cyc_period = 24'd10; cyc_en = 1'b1;
        pls_bad = 0; pls_cnt = 0; edge_bad = 0;
        for (int i = 1; i <= 35; i++) begin
            tick(1);
            if (cyctrig_pls) pls_cnt++;
            if (cyctrig_pls !== ((i % 10) == 0)) pls_bad++;
            if (i == 12 && trig_out !== 1'b0) edge_bad++;
            if (i == 13 && trig_out !== 1'b1) edge_bad++;
        end
        checks++;
        if (pls_bad != 0 || pls_cnt != 3) begin
            failures++;
            $display("FAIL cyc_pulses got count=%0d bad=%0d exp count=3 bad=0", pls_cnt, pls_bad);
        end
        checks++;
        if (edge_bad != 0) begin
            failures++;
            $display("FAIL cyc_latency got bad=%0d exp=0", edge_bad);
        end
        checks++;
        if (trig_cnt !== 32'd3 || trig_src !== 2'b11) begin
            failures++;
            $display("FAIL cyc_trig got cnt=%0d src=%b exp cnt=3 src=11", trig_cnt, trig_src);
        end
        cyc_period = '0;
        pls_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (cyctrig_pls) pls_cnt++;
        end
        checks++;
        if (pls_cnt != 0 || trig_cnt !== 32'd3) begin
            failures++;
            $display("FAIL cyc_zero_period got pulses=%0d cnt=%0d exp 0 3", pls_cnt, trig_cnt);
        end
        cyc_en = 1'b0;
    endtask

    task automatic test_simul_holdoff;
        apply_reset();
        mode = 2'b00; ch_mask = 3'b111; holdoff = 8'd20;
        trig_in = 1'b1; overth = 3'b001;
        tick(3);           // accept edge A
        checks++;
        if (trig_out !== 1'b1 || trig_src !== 2'b01 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL simul_src got out=%b src=%b drop=%0d exp out=1 src=01 drop=0",
                     trig_out, trig_src, drop_cnt);
        end
        trig_in = 1'b0; overth = 3'b000;
        tick(5);           // A+5, in hold-off
        checks++;
        if ({trig_out, busy} !== 2'b01) begin
            failures++;
            $display("FAIL hold_busy got=%b exp=01", {trig_out, busy});
        end
        trig_in = 1'b1;
        tick(4);           // A+9, edge rejected at A+8
        checks++;
        if (drop_cnt !== 16'd1 || trig_cnt !== 32'd1) begin
            failures++;
            $display("FAIL hold_reject got drop=%0d cnt=%0d exp drop=1 cnt=1", drop_cnt, trig_cnt);
        end
        tick(14);          // A+23, last hold cycle
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_len got busy=%b exp=1", busy);
        end
        tick(1);           // A+24
        checks++;
        if (busy !== 1'b0 || trig_src !== 2'b01) begin
            failures++;
            $display("FAIL hold_end got busy=%b src=%b exp busy=0 src=01", busy, trig_src);
        end
        trig_in = 1'b0;
        holdoff = '0;
        tick(2);
    endtask

    task automatic test_stun;
        int seen;
        apply_reset();
        mode = 2'b00; holdoff = '0; trigger_stun = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            trig_in = 1'b1;
            for (int j = 0; j < 2; j++) begin tick(1); if (trig_out) seen++; end
            trig_in = 1'b0;
            for (int j = 0; j < 2; j++) begin tick(1); if (trig_out) seen++; end
        end
        for (int j = 0; j < 3; j++) begin tick(1); if (trig_out) seen++; end
        checks++;
        if (seen != 0 || trig_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stun_block got high=%0d cnt=%0d exp 0 0", seen, trig_cnt);
        end
        checks++;
        if (drop_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stun_drops got=%0d exp=3", drop_cnt);
        end
        // Stun raised mid-pulse must not shorten it.
        trigger_stun = 1'b0;
        trig_in = 1'b1;
        tick(3);           // A
        trigger_stun = 1'b1;
        tick(3);           // A+3
        checks++;
        if (trig_out !== 1'b1) begin
            failures++;
            $display("FAIL stun_no_truncate got=%b exp=1", trig_out);
        end
        tick(1);           // A+4
        checks++;
        if (trig_out !== 1'b0 || trig_cnt !== 32'd1) begin
            failures++;
            $display("FAIL stun_pulse_end got out=%b cnt=%0d exp 0 1", trig_out, trig_cnt);
        end
        trigger_stun = 1'b0;
        trig_in = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid_pulse;
        trig_in = 1'b1;
        tick(4);           // A+1
        checks++;
        if (trig_out !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_pulse got=%b exp=1", trig_out);
        end
        reset_i = 1'b1;
        tick(1);
        checks++;
        if ({trig_out, cyctrig_pls, busy, trig_src} !== 5'b0 || trig_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid_pulse got flags=%b cnt=%0d drop=%0d exp 00000 0 0",
                     {trig_out, cyctrig_pls, busy, trig_src}, trig_cnt, drop_cnt);
        end
        reset_i = 1'b0;    // trig_in still high: first post-reset edge is a rise
        tick(2);
        checks++;
        if (trig_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_release_early got=%b exp=0", trig_out);
        end
        tick(1);
        checks++;
        if (trig_out !== 1'b1 || trig_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rst_release_fire got out=%b cnt=%0d exp 1 1", trig_out, trig_cnt);
        end
        trig_in = 1'b0;
        tick(6);
    endtask

    task automatic test_back_to_back;
        apply_reset();
        mode = 2'b10; holdoff = '0;
        trig_in = 1'b1; tick(1);   // E0
        trig_in = 1'b0; tick(4);   // E0+1 .. E0+4
        trig_in = 1'b1; tick(1);   // E0+5 = A+3
        trig_in = 1'b0;
        tick(1);                   // A+4
        checks++;
        if (trig_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got=%b exp=0", trig_out);
        end
        tick(1);                   // A+5
        checks++;
        if (trig_out !== 1'b1 || trig_cnt !== 32'd2 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL b2b_second got out=%b cnt=%0d drop=%0d exp 1 2 0", trig_out, trig_cnt, drop_cnt);
        end
        tick(6);
    endtask

    initial begin
        test_reset();
        test_self_or();
        test_majority();
        test_cyclic();
        test_simul_holdoff();
        test_stun();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
